// File: rtl/simon_seq_engine.sv
// Simon-style memory game sequencer: grows a random button sequence one step
// per round, plays it back on a tick timebase, then checks the player's echo.
module simon_seq_engine #(
   parameter int unsigned NUM_W         = 2,
   parameter int unsigned DEPTH         = 16,
   parameter int unsigned ON_TICKS      = 30,
   parameter int unsigned OFF_TICKS     = 30,
   parameter int unsigned TIMEOUT_TICKS = 120,
   parameter logic [15:0] SEED          = 16'hACE1,
   localparam int unsigned SCORE_W      = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               tick,
   input  logic               start,
   input  logic [NUM_W-1:0]   player_num,
   input  logic               player_valid,
   output logic               simon_turn,
   output logic [NUM_W-1:0]   simon_num,
   output logic               simon_lit,
   output logic [SCORE_W-1:0] score,
   output logic               game_over,
   output logic               win
);

   localparam int unsigned MAX_ON_OFF = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
   localparam int unsigned MAX_TICKS  = (MAX_ON_OFF > TIMEOUT_TICKS) ? MAX_ON_OFF : TIMEOUT_TICKS;
   localparam int unsigned CNT_W      = $clog2(MAX_TICKS + 1);
   localparam int unsigned IDX_W      = $clog2(DEPTH);

   localparam logic [CNT_W-1:0]   ON_LAST  = CNT_W'(ON_TICKS - 1);
   localparam logic [CNT_W-1:0]   OFF_LAST = CNT_W'(OFF_TICKS - 1);
   localparam logic [CNT_W-1:0]   TO_LAST  = CNT_W'(TIMEOUT_TICKS - 1);
   localparam logic [SCORE_W-1:0] LEN_MAX  = SCORE_W'(DEPTH);

   typedef enum logic [2:0] {
      StIdle,
      StAppend,
      StShowOn,
      StShowOff,
      StWaitIn,
      StLose,
      StWin
   } state_e;

   state_e             r_state, w_state_d;
   logic [15:0]        r_lfsr;
   logic               w_fb;
   logic [NUM_W-1:0]   r_mem [DEPTH];
   logic [SCORE_W-1:0] r_len, w_len_d;
   logic [SCORE_W-1:0] r_score, w_score_d;
   logic [IDX_W-1:0]   r_idx, w_idx_d;
   logic [CNT_W-1:0]   r_tcnt, w_tcnt_d;
   logic               w_we;
   logic [IDX_W-1:0]   w_waddr;
   logic [NUM_W-1:0]   w_wdata;
   logic [NUM_W-1:0]   w_mem_rd;
   logic [NUM_W-1:0]   w_num_d;
   logic               w_last;
   logic               r_turn, r_lit, r_over, r_win;
   logic [NUM_W-1:0]   r_num;

   // x^16 + x^14 + x^13 + x^11; a nonzero seed never reaches the all-zero state
   assign w_fb     = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
   assign w_we     = (r_state == StAppend);
   assign w_waddr  = r_len[IDX_W-1:0];
   assign w_wdata  = r_lfsr[NUM_W-1:0];
   assign w_mem_rd = r_mem[r_idx];
   assign w_last   = (SCORE_W'(r_idx) == (r_len - SCORE_W'(1)));

   // Free-running LFSR, advances on every clk so the sequence depends on player timing
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_lfsr <= SEED;
      else       r_lfsr <= {r_lfsr[14:0], w_fb};
   end

   // Sequence memory; not cleared, every entry is written before it is read
   always_ff @(posedge clk) begin
      if (w_we) r_mem[w_waddr] <= w_wdata;
   end

   // Game state, counters and score
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= StIdle;
         r_len   <= '0;
         r_score <= '0;
         r_idx   <= '0;
         r_tcnt  <= '0;
      end else begin
         r_state <= w_state_d;
         r_len   <= w_len_d;
         r_score <= w_score_d;
         r_idx   <= w_idx_d;
         r_tcnt  <= w_tcnt_d;
      end
   end

   // Next-state logic for the game FSM
   always_comb begin
      w_state_d = r_state;
      w_len_d   = r_len;
      w_score_d = r_score;
      w_idx_d   = r_idx;
      w_tcnt_d  = r_tcnt;
      unique case (r_state)
         StIdle, StLose, StWin: begin
            if (start) begin
               w_score_d = '0;
               w_len_d   = '0;
               w_idx_d   = '0;
               w_tcnt_d  = '0;
               w_state_d = StAppend;
            end
         end
         StAppend: begin
            w_len_d   = r_len + SCORE_W'(1);
            w_idx_d   = '0;
            w_tcnt_d  = '0;
            w_state_d = StShowOn;
         end
         StShowOn: begin
            if (tick) begin
               if (r_tcnt == ON_LAST) begin
                  w_tcnt_d  = '0;
                  w_state_d = StShowOff;
               end else begin
                  w_tcnt_d = r_tcnt + CNT_W'(1);
               end
            end
         end
         StShowOff: begin
            if (tick) begin
               if (r_tcnt == OFF_LAST) begin
                  w_tcnt_d = '0;
                  if (w_last) begin
                     w_idx_d   = '0;
                     w_state_d = StWaitIn;
                  end else begin
                     w_idx_d   = r_idx + IDX_W'(1);
                     w_state_d = StShowOn;
                  end
               end else begin
                  w_tcnt_d = r_tcnt + CNT_W'(1);
               end
            end
         end
         StWaitIn: begin
            // A press wins over a coincident timeout expiry
            if (player_valid) begin
               if (player_num == w_mem_rd) begin
                  w_tcnt_d = '0;
                  if (!w_last) begin
                     w_idx_d = r_idx + IDX_W'(1);
                  end else begin
                     w_score_d = r_score + SCORE_W'(1);
                     w_state_d = (r_len == LEN_MAX) ? StWin : StAppend;
                  end
               end else begin
                  w_state_d = StLose;
               end
            end else if (tick) begin
               if (r_tcnt == TO_LAST) w_state_d = StLose;
               else                   w_tcnt_d  = r_tcnt + CNT_W'(1);
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   // Shown button for the next cycle; bypasses the memory when entry 0 is written this cycle
   always_comb begin
      w_num_d = r_num;
      if (w_state_d == StShowOn) begin
         w_num_d = (w_we && (w_waddr == w_idx_d)) ? w_wdata : r_mem[w_idx_d];
      end
   end

   // Registered outputs decoded from the next state so they line up with r_state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_turn <= 1'b0;
         r_lit  <= 1'b0;
         r_over <= 1'b0;
         r_win  <= 1'b0;
         r_num  <= '0;
      end else begin
         r_turn <= (w_state_d == StAppend) || (w_state_d == StShowOn) ||
                   (w_state_d == StShowOff);
         r_lit  <= (w_state_d == StShowOn);
         r_over <= (w_state_d == StLose) || (w_state_d == StWin);
         r_win  <= (w_state_d == StWin);
         r_num  <= w_num_d;
      end
   end

   assign simon_turn = r_turn;
   assign simon_num  = r_num;
   assign simon_lit  = r_lit;
   assign score      = r_score;
   assign game_over  = r_over;
   assign win        = r_win;

endmodule

// File: tb/tb_simon_seq_engine.sv
// Testbench for simon_seq_engine: a default build (tick every clk) and a small
// NUM_W=3/DEPTH=4 build (random sparse ticks), checked against a queue-based model.
module tb_simon_seq_engine;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset = 1'b1;
   logic       tick = 1'b0;
   logic       start = 1'b0;
   logic       valid = 1'b0;
   logic [2:0] pnum = '0;
   logic       sel = 1'b0;   // 0: default build, 1: small build

   logic       turn_a, lit_a, over_a, win_a;
   logic [1:0] num_a;
   logic [4:0] score_a;
   logic       turn_b, lit_b, over_b, win_b;
   logic [2:0] num_b;
   logic [2:0] score_b;

   logic w_start_a, w_start_b, w_valid_a, w_valid_b;
   assign w_start_a = start & ~sel;
   assign w_start_b = start & sel;
   assign w_valid_a = valid & ~sel;
   assign w_valid_b = valid & sel;

   simon_seq_engine u_dut_a (
      .clk          (clk),
      .reset        (reset),
      .tick         (tick),
      .start        (w_start_a),
      .player_num   (pnum[1:0]),
      .player_valid (w_valid_a),
      .simon_turn   (turn_a),
      .simon_num    (num_a),
      .simon_lit    (lit_a),
      .score        (score_a),
      .game_over    (over_a),
      .win          (win_a)
   );

   simon_seq_engine #(
      .NUM_W         (3),
      .DEPTH         (4),
      .ON_TICKS      (3),
      .OFF_TICKS     (2),
      .TIMEOUT_TICKS (20)
   ) u_dut_b (
      .clk          (clk),
      .reset        (reset),
      .tick         (tick),
      .start        (w_start_b),
      .player_num   (pnum),
      .player_valid (w_valid_b),
      .simon_turn   (turn_b),
      .simon_num    (num_b),
      .simon_lit    (lit_b),
      .score        (score_b),
      .game_over    (over_b),
      .win          (win_b)
   );

   // View of whichever build is selected
   logic       o_turn, o_lit, o_over, o_win;
   logic [2:0] o_num;
   logic [4:0] o_score;
   assign o_turn  = sel ? turn_b : turn_a;
   assign o_lit   = sel ? lit_b  : lit_a;
   assign o_over  = sel ? over_b : over_a;
   assign o_win   = sel ? win_b  : win_a;
   assign o_num   = sel ? num_b  : {1'b0, num_a};
   assign o_score = sel ? {2'b00, score_b} : score_a;

   // Reference LFSR: x^16 + x^14 + x^13 + x^11, stepped once per clk from the seed
   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   logic [15:0] m_lfsr;
   always @(posedge clk or posedge reset) begin
      if (reset) m_lfsr <= 16'hACE1;
      else       m_lfsr <= lfsr_next(m_lfsr);
   end

   int         n_chk = 0;
   int         n_fail = 0;
   logic [2:0] exp_seq[$];
   bit         dense = 1'b1;
   bit         t_last = 1'b0;
   int         on_t, off_t, to_t, depth;
   logic [2:0] mask3;

   task automatic set_build();
      on_t  = sel ? 3 : 30;
      off_t = sel ? 2 : 30;
      to_t  = sel ? 20 : 120;
      depth = sel ? 4 : 16;
      mask3 = sel ? 3'b111 : 3'b011;
   endtask

   // One clock: choose this cycle's tick, pass the edge, sample 1 time unit later
   task automatic step();
      tick = dense ? 1'b1 : ($urandom_range(0, 2) != 0);
      @(posedge clk);
      #1;
      t_last = tick;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      start = 1'b0;
      valid = 1'b0;
      pnum  = '0;
      step();
      step();
      reset = 1'b0;
   endtask

   // Called in the APPEND cycle: record the step the model expects to be appended
   task automatic capture_append();
      n_chk++;
      if (o_turn !== 1'b1) begin
         n_fail++;
         $display("FAIL append_turn: got %0b, want 1", o_turn);
      end
      exp_seq.push_back(m_lfsr[2:0] & mask3);
   endtask

   task automatic start_game();
      start = 1'b1;
      step();
      start = 1'b0;
      exp_seq.delete();
      n_chk++;
      if (o_score !== 5'd0 || o_over !== 1'b0) begin
         n_fail++;
         $display("FAIL start_clear: got score=%0d over=%0b, want score=0 over=0", o_score, o_over);
      end
      capture_append();
   endtask

   // From APPEND: check every step of playback, counting tick strobes in each phase
   task automatic play_round(input bit inject);
      int n, bad, iters, k;
      k = exp_seq.size();
      step();
      for (int i = 0; i < k; i++) begin
         n = 0; bad = 0; iters = 0;
         while (o_lit === 1'b1 && iters < 8 * (on_t + 4)) begin
            if (o_num !== exp_seq[i]) bad++;
            if (inject && i == 0) begin
               valid = (iters == 2);
               pnum  = exp_seq[0];
               start = (iters == 4);
            end
            step();
            iters++;
            if (t_last) n++;
         end
         valid = 1'b0;
         start = 1'b0;
         n_chk++;
         if (n !== on_t) begin
            n_fail++;
            $display("FAIL on_ticks step %0d: got %0d, want %0d", i, n, on_t);
         end
         n_chk++;
         if (bad !== 0) begin
            n_fail++;
            $display("FAIL shown_num step %0d: got %0d wrong cycles, want 0 (value %0d)", i, bad,
                     exp_seq[i]);
         end
         n = 0; iters = 0;
         while (o_lit === 1'b0 && o_turn === 1'b1 && iters < 8 * (off_t + 4)) begin
            step();
            iters++;
            if (t_last) n++;
         end
         n_chk++;
         if (n !== off_t) begin
            n_fail++;
            $display("FAIL off_ticks step %0d: got %0d, want %0d", i, n, off_t);
         end
      end
      n_chk++;
      if (o_turn !== 1'b0 || o_lit !== 1'b0 || o_over !== 1'b0) begin
         n_fail++;
         $display("FAIL wait_in_entry: got turn=%0b lit=%0b over=%0b, want 0 0 0", o_turn, o_lit,
                  o_over);
      end
   endtask

   // Echo the whole sequence with random gaps shorter than the timeout
   task automatic echo_round();
      int k;
      k = exp_seq.size();
      for (int i = 0; i < k; i++) begin
         repeat ($urandom_range(0, 3)) step();
         valid = 1'b1;
         pnum  = exp_seq[i];
         step();
         valid = 1'b0;
         if (i < k - 1) begin
            n_chk++;
            if (o_turn !== 1'b0 || o_over !== 1'b0) begin
               n_fail++;
               $display("FAIL mid_press %0d: got turn=%0b over=%0b, want 0 0", i, o_turn, o_over);
            end
         end
      end
   endtask

   task automatic next_round();
      play_round(1'b0);
      echo_round();
   endtask

   task automatic run_full_game();
      do_reset();
      start_game();
      for (int r = 1; r <= depth; r++) begin
         next_round();
         if (r < depth) begin
            n_chk++;
            if (o_score !== 5'(r) || o_over !== 1'b0) begin
               n_fail++;
               $display("FAIL round_score %0d: got score=%0d over=%0b, want %0d 0", r, o_score,
                        o_over, r);
            end
            capture_append();
         end else begin
            n_chk++;
            if (o_win !== 1'b1 || o_over !== 1'b1 || o_turn !== 1'b0) begin
               n_fail++;
               $display("FAIL win_flags: got win=%0b over=%0b turn=%0b, want 1 1 0", o_win,
                        o_over, o_turn);
            end
            n_chk++;
            if (o_score !== 5'(depth)) begin
               n_fail++;
               $display("FAIL win_score: got %0d, want %0d", o_score, depth);
            end
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      n_chk++;
      if ({turn_a, num_a, lit_a, score_a, over_a, win_a} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs_a: got %0h, want 0",
                  {turn_a, num_a, lit_a, score_a, over_a, win_a});
      end
      n_chk++;
      if ({turn_b, num_b, lit_b, score_b, over_b, win_b} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs_b: got %0h, want 0",
                  {turn_b, num_b, lit_b, score_b, over_b, win_b});
      end
      reset = 1'b0;
      valid = 1'b1;
      pnum  = 3'd1;
      step();
      valid = 1'b0;
      step();
      n_chk++;
      if ({o_turn, o_over, o_score} !== '0) begin
         n_fail++;
         $display("FAIL idle_ignores_press: got %0h, want 0", {o_turn, o_over, o_score});
      end
   endtask

   task automatic test_first_round();
      do_reset();
      start_game();
      play_round(1'b0);
      n_chk++;
      if (o_score !== 5'd0) begin
         n_fail++;
         $display("FAIL first_round_score: got %0d, want 0", o_score);
      end
   endtask

   task automatic test_wrong_button();
      logic [2:0] wrong;
      do_reset();
      start_game();
      next_round();
      capture_append();
      next_round();
      capture_append();
      play_round(1'b0);
      valid = 1'b1;
      pnum  = exp_seq[0];
      step();
      valid = 1'b0;
      n_chk++;
      if (o_over !== 1'b0) begin
         n_fail++;
         $display("FAIL wrong_first_ok: got over=%0b, want 0", o_over);
      end
      wrong = (exp_seq[1] + 3'($urandom_range(1, 3))) & mask3;
      valid = 1'b1;
      pnum  = wrong;
      step();
      valid = 1'b0;
      n_chk++;
      if (o_over !== 1'b1 || o_win !== 1'b0 || o_turn !== 1'b0) begin
         n_fail++;
         $display("FAIL lose_flags: got over=%0b win=%0b turn=%0b, want 1 0 0", o_over, o_win,
                  o_turn);
      end
      n_chk++;
      if (o_score !== 5'd2) begin
         n_fail++;
         $display("FAIL lose_score: got %0d, want 2", o_score);
      end
      start_game();
   endtask

   task automatic test_timeout();
      int n;
      do_reset();
      start_game();
      play_round(1'b0);
      n = 0;
      while (o_over === 1'b0 && n < to_t + 10) begin
         step();
         n++;
      end
      n_chk++;
      if (n !== to_t || o_win !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_ticks: got %0d ticks win=%0b, want %0d ticks win=0", n, o_win,
                  to_t);
      end
      start_game();
      play_round(1'b0);
      repeat (to_t - 1) step();
      n_chk++;
      if (o_over !== 1'b0) begin
         n_fail++;
         $display("FAIL no_early_lose: got over=%0b, want 0", o_over);
      end
      valid = 1'b1;
      pnum  = exp_seq[0];
      step();
      valid = 1'b0;
      n_chk++;
      if (o_over !== 1'b0 || o_turn !== 1'b1 || o_score !== 5'd1) begin
         n_fail++;
         $display("FAIL press_on_last_tick: got over=%0b turn=%0b score=%0d, want 0 1 1", o_over,
                  o_turn, o_score);
      end
   endtask

   task automatic test_ignored_inputs();
      do_reset();
      start_game();
      next_round();
      capture_append();
      play_round(1'b1);
      n_chk++;
      if (o_score !== 5'd1) begin
         n_fail++;
         $display("FAIL inject_score: got %0d, want 1", o_score);
      end
      repeat (3) step();
      n_chk++;
      if (o_turn !== 1'b0 || o_over !== 1'b0) begin
         n_fail++;
         $display("FAIL no_queued_press: got turn=%0b over=%0b, want 0 0", o_turn, o_over);
      end
      echo_round();
      n_chk++;
      if (o_turn !== 1'b1 || o_score !== 5'd2 || o_over !== 1'b0) begin
         n_fail++;
         $display("FAIL inject_next_round: got turn=%0b score=%0d over=%0b, want 1 2 0", o_turn,
                  o_score, o_over);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      start_game();
      repeat (3) step();
      n_chk++;
      if (o_lit !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_reset_lit: got %0b, want 1", o_lit);
      end
      reset = 1'b1;
      #1;
      n_chk++;
      if ({turn_a, num_a, lit_a, score_a, over_a, win_a} !== '0) begin
         n_fail++;
         $display("FAIL reset_async: got %0h, want 0",
                  {turn_a, num_a, lit_a, score_a, over_a, win_a});
      end
      step();
      n_chk++;
      if ({turn_a, num_a, lit_a, score_a, over_a, win_a} !== '0) begin
         n_fail++;
         $display("FAIL reset_held: got %0h, want 0",
                  {turn_a, num_a, lit_a, score_a, over_a, win_a});
      end
      reset = 1'b0;
      start_game();
      next_round();
      n_chk++;
      if (o_turn !== 1'b1 || o_score !== 5'd1) begin
         n_fail++;
         $display("FAIL post_reset_round: got turn=%0b score=%0d, want 1 1", o_turn, o_score);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: time limit reached before the end of the test");
      $fatal(1, "watchdog");
   end

   initial begin
      sel   = 1'b0;
      dense = 1'b1;
      set_build();
      test_reset();
      test_first_round();
      run_full_game();
      test_wrong_button();
      test_timeout();
      test_ignored_inputs();
      test_reset_mid();
      sel   = 1'b1;
      dense = 1'b0;
      set_build();
      run_full_game();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
